// File: rtl/trig_pkg.sv
// Shared constants and the issue-tag type for the trig lookup arbiter.
// Latency: none (types and constants only).
// Backpressure: none.
package trig_pkg;

    localparam int DEG_W    = 12;
    localparam int VAL_W    = 10;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant over an eligibility vector, starting at ptr_i.
// Latency: purely combinational, grant and next pointer in the same cycle.
// Backpressure: ineligible requesters are skipped; no grant when none eligible.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            gnt_vld_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic [IDW-1:0]  ptr_nxt_o
);

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % NREQ);
    endfunction

    // Scan from the farthest offset back to ptr so the nearest eligible index wins.
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (elig_i[wrap(int'(ptr_i) + off)]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = wrap(int'(ptr_i) + off);
            end
        end
        if (gnt_vld_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
        ptr_nxt_o = gnt_vld_o ? wrap(int'(gnt_idx_o) + 1) : ptr_i;
    end

endmodule

// File: rtl/trig_arbiter.sv
// Shares one handshake-less trig lookup among NREQ requesters, round-robin, one issue per cycle.
// Latency: accept-to-response TRIG_LAT+1 cycles, responses in issue order.
// Backpressure: per-requester in-flight cap OUTS_MAX gates grants; response side has none.
module trig_arbiter
    import trig_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int TRIG_LAT = 2,
    parameter  int OUTS_MAX = 3,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DEG_W-1:0] req_degree,
    input  logic [NREQ-1:0]       req_iscos,
    output logic [NREQ-1:0]       gnt,
    output logic [DEG_W-1:0]      trig_degree,
    output logic                  trig_iscos,
    input  logic [VAL_W-1:0]      trig_value,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [VAL_W-1:0]      rsp_value,
    output logic                  busy
);

    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [2:0]       cnt_q [NREQ];
    logic [2:0]       cnt_d [NREQ];
    tag_t             tag_q [TRIG_LAT+1];
    tag_t             tag_in;
    tag_t             tag_out;
    logic [DEG_W-1:0] trig_degree_q;
    logic             trig_iscos_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [VAL_W-1:0] rsp_value_q;
    logic             busy_q;
    logic             busy_d;
    logic [NREQ-1:0]  elig;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;

    // The last delay stage lines up with trig_value carrying that request's result.
    assign tag_out = tag_q[TRIG_LAT];

    // A requester may win only while under its in-flight cap; nothing wins during reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = !rst && req[i] && (cnt_q[i] < 3'(OUTS_MAX));
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx),
        .ptr_nxt_o (ptr_d)
    );

    // Tag entering the delay line this cycle; an idle slot carries valid=0.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = gnt_vld;
        tag_in.id    = TAG_ID_W'(gnt_idx);
    end

    // In-flight counts: +1 on issue, -1 when the matching result leaves; both at once cancel.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((gnt_vld && gnt_idx == IDW'(i)) && !(tag_out.valid && tag_out.id == TAG_ID_W'(i))) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end else if (!(gnt_vld && gnt_idx == IDW'(i)) && (tag_out.valid && tag_out.id == TAG_ID_W'(i))) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
        end
    end

    // Busy reflects the current in-flight state, so it trails the last response by a cycle.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (cnt_q[i] != 3'd0) begin
                busy_d = 1'b1;
            end
        end
        for (int j = 0; j <= TRIG_LAT; j++) begin
            if (tag_q[j].valid) begin
                busy_d = 1'b1;
            end
        end
    end

    // State: pointer, counters, trig operands, tag delay line and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            trig_degree_q <= '0;
            trig_iscos_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_value_q   <= '0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j <= TRIG_LAT; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (gnt_vld) begin
                trig_degree_q <= req_degree[int'(gnt_idx)*DEG_W +: DEG_W];
                trig_iscos_q  <= req_iscos[gnt_idx];
            end
            tag_q[0] <= tag_in;
            for (int j = 1; j <= TRIG_LAT; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
            rsp_valid_q <= tag_out.valid;
            if (tag_out.valid) begin
                rsp_id_q    <= tag_out.id[IDW-1:0];
                rsp_value_q <= trig_value;
            end
        end
    end

    assign trig_degree = trig_degree_q;
    assign trig_iscos  = trig_iscos_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_value   = rsp_value_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_trig_arbiter.sv
// Bench for trig_arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: model expects each result TRIG_LAT+1 edges after its issue edge.
// Backpressure: requests are held with their payload until granted.
module tb_trig_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] req_degree;
    logic [3:0]  req_iscos;
    logic [3:0]  gnt;
    logic [11:0] trig_degree;
    logic        trig_iscos;
    logic [9:0]  trig_value;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [9:0]  rsp_value;
    logic        busy;

    always #5 clk = ~clk;

    trig_arbiter #(.NREQ(4), .TRIG_LAT(2), .OUTS_MAX(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_degree  (req_degree),
        .req_iscos   (req_iscos),
        .gnt         (gnt),
        .trig_degree (trig_degree),
        .trig_iscos  (trig_iscos),
        .trig_value  (trig_value),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_value   (rsp_value),
        .busy        (busy)
    );

    function automatic logic [9:0] fval(input logic [11:0] d, input logic c);
        return d[9:0] ^ {c, 9'b0};
    endfunction

    // Behavioural trig unit: result valid two edges after its operands change.
    logic [9:0] tv1;
    always @(posedge clk) begin
        tv1        <= fval(trig_degree, trig_iscos);
        trig_value <= tv1;
    end

    typedef struct {
        int         id;
        logic [9:0] val;
        int         iss_edge;
    } fl_t;

    fl_t         inflight[$];
    int          outs_m[4];
    int          ptr_m;
    int          edge_n;
    int          last_g;
    logic [3:0]  gnt_obs;
    logic        rv_e;
    int          id_e;
    logic [9:0]  val_e;
    logic [11:0] deg_e;
    logic        cos_e;
    logic        busy_e;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check grant mid-cycle, advance the model at the edge, check registered outputs.
    task automatic tick();
        int          g;
        logic [11:0] dg;
        logic        ic;
        fl_t         f;
        @(negedge clk);
        g  = -1;
        dg = '0;
        ic = 1'b0;
        if (!rst) begin
            for (int off = 0; off < 4; off++) begin
                int idx;
                idx = (ptr_m + off) % 4;
                if (g < 0 && req[idx] && outs_m[idx] < 3) g = idx;
            end
        end
        gnt_obs = gnt;
        chk("gnt", {28'd0, gnt}, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            dg = req_degree[12*g +: 12];
            ic = req_iscos[g];
        end
        @(posedge clk);
        busy_e = (inflight.size() != 0);
        rv_e   = 1'b0;
        if (rst) begin
            inflight.delete();
            for (int i = 0; i < 4; i++) outs_m[i] = 0;
            ptr_m  = 0;
            deg_e  = '0;
            cos_e  = 1'b0;
            id_e   = 0;
            val_e  = '0;
            busy_e = 1'b0;
            g      = -1;
        end else begin
            if (inflight.size() != 0 && inflight[0].iss_edge + 3 == edge_n) begin
                f     = inflight.pop_front();
                rv_e  = 1'b1;
                id_e  = f.id;
                val_e = f.val;
                outs_m[f.id]--;
            end
            if (g >= 0) begin
                inflight.push_back('{id: g, val: fval(dg, ic), iss_edge: edge_n});
                outs_m[g]++;
                ptr_m = (g + 1) % 4;
                deg_e = dg;
                cos_e = ic;
            end
        end
        edge_n++;
        last_g = g;
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, rv_e});
        chk("rsp_id", {30'd0, rsp_id}, id_e);
        chk("rsp_value", {22'd0, rsp_value}, {22'd0, val_e});
        chk("trig_degree", {20'd0, trig_degree}, {20'd0, deg_e});
        chk("trig_iscos", {31'd0, trig_iscos}, {31'd0, cos_e});
        chk("busy", {31'd0, busy}, {31'd0, busy_e});
    endtask

    // Raise requests in mask with probability pct; a granted requester drops its request.
    task automatic run(input int n, input logic [3:0] mask, input int pct);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && !req[i] && int'($urandom_range(99)) < pct) begin
                    req[i]               = 1'b1;
                    req_degree[12*i +: 12] = 12'($urandom);
                    req_iscos[i]         = 1'($urandom);
                end
            end
            tick();
            if (last_g >= 0) req[last_g] = 1'b0;
        end
    endtask

    task automatic single(input int id, input logic [11:0] d, input logic c,
                          input logic [9:0] exp_val, input string tag);
        req[id]                 = 1'b1;
        req_degree[12*id +: 12] = d;
        req_iscos[id]           = c;
        tick();
        chk({tag, "_gnt"}, {28'd0, gnt_obs}, 32'd1 << id);
        req[id] = 1'b0;
        tick();
        tick();
        tick();
        chk({tag, "_rv"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_id"}, {30'd0, rsp_id}, id);
        chk({tag, "_val"}, {22'd0, rsp_value}, {22'd0, exp_val});
        tick();
        chk({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        edge_n     = 0;
        ptr_m      = 0;
        last_g     = -1;
        rst        = 1'b1;
        req        = '0;
        req_degree = '0;
        req_iscos  = '0;
        for (int i = 0; i < 4; i++) outs_m[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request right after reset, sine path.
        single(2, 12'd256, 1'b0, 10'd256, "s1");
        run(4, 4'b0000, 0);

        // All four requesting continuously.
        run(12, 4'b1111, 100);
        run(12, 4'b0000, 0);

        // One requester against its in-flight cap.
        run(16, 4'b0010, 100);
        run(10, 4'b0000, 0);

        // Cosine path.
        single(3, 12'd5, 1'b1, 10'd517, "s4");
        run(4, 4'b0000, 0);

        // Reset one cycle after two issues discards both.
        req[0] = 1'b1; req_degree[11:0] = 12'd100; req_iscos[0] = 1'b0;
        req[1] = 1'b1; req_degree[23:12] = 12'd200; req_iscos[1] = 1'b1;
        run(2, 4'b0000, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(6, 4'b0000, 0);
        chk("s5_busy", {31'd0, busy}, 32'd0);
        single(2, 12'd256, 1'b0, 10'd256, "s5b");
        run(4, 4'b0000, 0);

        // Steady single-requester stream, then drain.
        run(24, 4'b0001, 100);
        run(10, 4'b0000, 0);

        // Random traffic.
        run(300, 4'b1111, 60);
        run(200, 4'b1111, 25);
        run(12, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
